// File: rtl/dpram_tile_reader.sv
// Tile read-address generator for the feature-map DPRAM, re-timing read data into a valid/ready stream.
// Optional `define DPRAM_TILE_READER_STALL_CNT_EN adds a saturating stall_cnt output.
module dpram_tile_reader #(
  parameter int ADDR_WIDTH = 19,
  parameter int DATA_WIDTH = 8,
  parameter int DIM_WIDTH  = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [DIM_WIDTH-1:0]  num_rows,
  input  logic [DIM_WIDTH-1:0]  num_cols,
  input  logic [DIM_WIDTH-1:0]  row_stride,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_row_end,
  output logic                  out_last
`ifdef DPRAM_TILE_READER_STALL_CNT_EN
  ,
  output logic [15:0]           stall_cnt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [DIM_WIDTH-1:0]  DIM_ONE  = 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

  state_t                  r_state, w_next_state;
  logic [DIM_WIDTH-1:0]    r_num_rows, r_num_cols, r_stride;
  logic [DIM_WIDTH-1:0]    r_row, r_col;
  logic [ADDR_WIDTH-1:0]   r_row_base, r_addr;
  logic                    r_rd_vld_p1, r_rd_row_end_p1, r_rd_last_p1;
  logic [DATA_WIDTH-1:0]   r_fifo_data [0:1];
  logic [1:0]              r_fifo_row_end, r_fifo_last;
  logic                    r_wr_ptr, r_rd_ptr;
  logic [1:0]              r_count;

  logic                    w_accept, w_zero, w_pop, w_issue;
  logic                    w_col_last, w_row_last, w_is_last;
  logic [1:0]              w_credit;
  logic [ADDR_WIDTH-1:0]   w_stride_ext;

  assign w_zero       = (num_rows == '0) || (num_cols == '0);
  assign w_accept     = (r_state == S_IDLE) && start;
  assign w_col_last   = (r_col == r_num_cols - DIM_ONE);
  assign w_row_last   = (r_row == r_num_rows - DIM_ONE);
  assign w_is_last    = w_col_last && w_row_last;
  assign w_stride_ext = {{(ADDR_WIDTH-DIM_WIDTH){1'b0}}, r_stride};
  assign w_pop        = out_valid && out_ready;
  // Credits: FIFO occupancy plus the read whose data lands next cycle; never exceed 2.
  assign w_credit     = r_count + {1'b0, r_rd_vld_p1};
  assign w_issue      = (r_state == S_RUN) &&
                        ((w_credit < 2'd2) || ((w_credit == 2'd2) && w_pop));

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next_state = w_zero ? S_DONE : S_RUN;
      S_RUN:   if (w_issue && w_is_last) w_next_state = S_DRAIN;
      S_DRAIN: if (w_pop && out_last) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == S_RUN) || (r_state == S_DRAIN);
    done = (r_state == S_DONE);
  end

  // Stage p0: address walk; mem_addr is the address presented this cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_addr     <= '0;
      r_row_base <= '0;
      r_row      <= '0;
      r_col      <= '0;
    end else if (w_accept && !w_zero) begin
      r_addr     <= base_addr;
      r_row_base <= base_addr;
      r_row      <= '0;
      r_col      <= '0;
    end else if (w_issue && !w_is_last) begin
      if (w_col_last) begin
        r_col      <= '0;
        r_row      <= r_row + DIM_ONE;
        r_row_base <= r_row_base + w_stride_ext;
        r_addr     <= r_row_base + w_stride_ext;
      end else begin
        r_col  <= r_col + DIM_ONE;
        r_addr <= r_addr + ADDR_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept && !w_zero) begin
      r_num_rows <= num_rows;
      r_num_cols <= num_cols;
      r_stride   <= row_stride;
    end
  end

  // Stage p1: issue flag and beat tags wait for the DPRAM read latency.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_vld_p1     <= 1'b0;
      r_rd_row_end_p1 <= 1'b0;
      r_rd_last_p1    <= 1'b0;
      r_wr_ptr        <= 1'b0;
      r_rd_ptr        <= 1'b0;
      r_count         <= 2'd0;
    end else begin
      r_rd_vld_p1     <= w_issue;
      r_rd_row_end_p1 <= w_issue && w_col_last;
      r_rd_last_p1    <= w_issue && w_is_last;
      if (r_rd_vld_p1) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)       r_rd_ptr <= ~r_rd_ptr;
      case ({r_rd_vld_p1, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Stage p2: 2-entry output FIFO.
  always_ff @(posedge clk) begin
    if (r_rd_vld_p1) begin
      r_fifo_data[r_wr_ptr]    <= mem_dout;
      r_fifo_row_end[r_wr_ptr] <= r_rd_row_end_p1;
      r_fifo_last[r_wr_ptr]    <= r_rd_last_p1;
    end
  end

  assign mem_addr    = r_addr;
  assign mem_we      = 1'b0;
  assign out_valid   = (r_count != 2'd0);
  assign out_data    = out_valid ? r_fifo_data[r_rd_ptr] : '0;
  assign out_row_end = out_valid && r_fifo_row_end[r_rd_ptr];
  assign out_last    = out_valid && r_fifo_last[r_rd_ptr];

`ifdef DPRAM_TILE_READER_STALL_CNT_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)                       r_stall_cnt <= '0;
    else if (w_accept)                r_stall_cnt <= '0;
    else if (out_valid && !out_ready) r_stall_cnt <= sat_inc16(r_stall_cnt);
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_dpram_tile_reader.sv
// Directed bench for dpram_tile_reader with a behavioural 1-cycle-latency DPRAM read port.
module tb_dpram_tile_reader;
  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [18:0] base_addr;
  logic [9:0]  num_rows, num_cols, row_stride;
  logic        busy, done, mem_we;
  logic [18:0] mem_addr;
  logic [7:0]  mem_dout;
  logic        out_valid, out_ready, out_row_end, out_last;
  logic [7:0]  out_data;
`ifdef DPRAM_TILE_READER_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  dpram_tile_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .num_rows(num_rows), .num_cols(num_cols), .row_stride(row_stride),
    .busy(busy), .done(done), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_dout(mem_dout), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_row_end(out_row_end), .out_last(out_last)
`ifdef DPRAM_TILE_READER_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  function automatic logic [7:0] fdat(input logic [18:0] a);
    return a[7:0] ^ a[15:8] ^ {a[18:16], 5'b0};
  endfunction

  always @(posedge clk) mem_dout <= fdat(mem_addr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // mode 0: out_ready always 1; mode 1: out_ready pattern 1,0,0 repeating.
  task automatic run_tile(input logic [18:0] base, input int rows, input int cols,
                          input int stride, input int mode, input bit inject);
    logic [18:0] ea [0:63];
    bit          ere [0:63];
    bit          ela [0:63];
    int          n, got, k, stalls;
    bit          pend, dn;
    logic [9:0]  pd;
    n = rows * cols;
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < cols; c++) begin
        ea[r*cols+c]  = 19'((base + r*stride + c) % 524288);
        ere[r*cols+c] = (c == cols-1);
        ela[r*cols+c] = (c == cols-1) && (r == rows-1);
      end
    @(negedge clk);
    base_addr = base; num_rows = 10'(rows); num_cols = 10'(cols);
    row_stride = 10'(stride); start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    got = 0; k = 0; stalls = 0; pend = 0; dn = 0; pd = '0;
    while (!dn && k < 200) begin
      @(negedge clk);
      out_ready = (mode == 0) ? 1'b1 : (k % 3 == 0);
      if (inject && k == 4) begin
        base_addr = 19'h0; num_rows = 10'd7; num_cols = 10'd7; start = 1'b1;
      end
      if (inject && k == 5) start = 1'b0;
      #1;
      if (k == 0) begin
        chk("busy_after_start", busy, 1);
        chk("first_addr", mem_addr, base);
        chk("valid_early", out_valid, 0);
      end
      if (mode == 0 && k < n) chk("addr_seq", mem_addr, ea[k]);
      if (pend) chk("stall_stable", {out_valid, out_data, out_row_end}, {1'b1, pd[9:2], pd[1]});
      if (pend) chk("stall_last", out_last, pd[0]);
      pend = 0;
      if (got == n) begin
        chk("done_pulse", done, 1);
        chk("busy_at_done", busy, 0);
        chk("valid_at_done", out_valid, 0);
        dn = 1;
      end else if (out_valid) begin
        if (out_ready) begin
          if (got == 0 && mode == 0) chk("first_beat_cycle", k, 2);
          chk("beat_data", out_data, fdat(ea[got]));
          chk("beat_row_end", out_row_end, ere[got]);
          chk("beat_last", out_last, ela[got]);
          got++;
        end else begin
          stalls++;
          pend = 1;
          pd = {out_data, out_row_end, out_last};
        end
      end else begin
        chk("done_early", done, 0);
      end
      k++;
    end
    if (!dn) chk("tile_timeout", got, n);
    @(negedge clk);
    #1;
    chk("done_one_cycle", done, 0);
    chk("idle_after_done", busy, 0);
`ifdef DPRAM_TILE_READER_STALL_CNT_EN
    chk("stall_cnt", stall_cnt, stalls);
`endif
  endtask

  initial begin
    logic [18:0] a0;
    int          seen, k;
    rst_n = 1'b0; start = 1'b0; out_ready = 1'b1;
    base_addr = '0; num_rows = '0; num_cols = '0; row_stride = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_outs", {out_data, out_row_end, out_last}, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_we", mem_we, 0);
    @(negedge clk) rst_n = 1'b1;

    run_tile(19'd100, 2, 3, 416, 0, 0);
    run_tile(19'd100, 2, 3, 416, 1, 0);
    run_tile(19'h7FFFE, 1, 4, 0, 0, 0);

    // Zero-size tile: straight to DONE without touching memory.
    @(negedge clk);
    a0 = mem_addr;
    num_rows = 10'd0; num_cols = 10'd5; base_addr = 19'd777; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    chk("zero_valid", out_valid, 0);
    chk("zero_addr", mem_addr, a0);
    @(posedge clk);
    #1;
    chk("zero_done_clear", done, 0);
    chk("zero_valid2", out_valid, 0);
    chk("zero_addr2", mem_addr, a0);

    // Reset in the middle of a 4x4 tile, then rerun it from the first beat.
    @(negedge clk);
    base_addr = 19'h300; num_rows = 10'd4; num_cols = 10'd4; row_stride = 10'd16;
    out_ready = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    seen = 0; k = 0;
    while (seen < 3 && k < 50) begin
      @(negedge clk);
      if (out_valid) seen++;
      k++;
    end
    chk("pre_rst_beats", seen, 3);
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_outs", {out_data, out_row_end, out_last}, 0);
    chk("mid_rst_addr", mem_addr, 0);
`ifdef DPRAM_TILE_READER_STALL_CNT_EN
    chk("mid_rst_stall", stall_cnt, 0);
`endif
    @(negedge clk) rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_quiet", {out_valid, busy}, 0);
    end
    run_tile(19'h300, 4, 4, 16, 0, 0);

    // start while busy must not disturb the running tile.
    run_tile(19'd100, 2, 3, 416, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
